// File: rtl/edge_pulse_if.sv
// Request/response bundle for edge_pulse_gen: edge commands in, generated level and strobes out.
// 'state' mirrors the generator FSM so checkers can bind to it without reaching into the design.
interface edge_pulse_if;
    logic       pos_req;
    logic       neg_req;
    logic       sig_out;
    logic       tx_pos;
    logic       tx_neg;
    logic       busy;
    logic       req_drop;
    logic [1:0] state;

    modport master (
        output pos_req, neg_req,
        input  sig_out, tx_pos, tx_neg, busy, req_drop, state
    );

    modport slave (
        input  pos_req, neg_req,
        output sig_out, tx_pos, tx_neg, busy, req_drop, state
    );
endinterface

// File: rtl/edge_pulse_gen.sv
// Turns single-cycle rise/fall request strobes into a level on sig_out that dwells at least
// HOLD_CYC cycles per level; one opposite-direction request can be queued during a hold.
module edge_pulse_gen #(
    parameter int HOLD_CYC = 4,
    parameter int CNT_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    edge_pulse_if.slave  bus
);

    localparam logic [1:0] IDLE_LO = 2'd0;
    localparam logic [1:0] HOLD_HI = 2'd1;
    localparam logic [1:0] IDLE_HI = 2'd2;
    localparam logic [1:0] HOLD_LO = 2'd3;

    localparam logic [1:0] PEND_NONE = 2'd0;
    localparam logic [1:0] PEND_RISE = 2'd1;
    localparam logic [1:0] PEND_FALL = 2'd2;

    // The transition cycle itself is the first dwell cycle, so the count starts one short.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYC - 1);

    logic [1:0]       state, state_nx;
    logic [1:0]       pend, pend_nx, pend_eval;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             sig_q, sig_nx;
    logic             tx_pos_q, tx_pos_nx;
    logic             tx_neg_q, tx_neg_nx;
    logic             busy_q;
    logic             drop_q;
    logic             conflict, pos_ok, neg_ok;

    assign conflict = bus.pos_req & bus.neg_req;
    assign pos_ok   = bus.pos_req & ~conflict;
    assign neg_ok   = bus.neg_req & ~conflict;

    always_comb begin
        state_nx  = state;
        pend_nx   = pend;
        pend_eval = pend;
        cnt_nx    = cnt;
        sig_nx    = sig_q;
        tx_pos_nx = 1'b0;
        tx_neg_nx = 1'b0;
        case (state)
            IDLE_LO: begin
                if (pos_ok) begin
                    sig_nx    = 1'b1;
                    tx_pos_nx = 1'b1;
                    cnt_nx    = RELOAD;
                    pend_nx   = PEND_NONE;
                    state_nx  = HOLD_HI;
                end
            end
            IDLE_HI: begin
                if (neg_ok) begin
                    sig_nx    = 1'b0;
                    tx_neg_nx = 1'b1;
                    cnt_nx    = RELOAD;
                    pend_nx   = PEND_NONE;
                    state_nx  = HOLD_LO;
                end
            end
            HOLD_HI: begin
                // The request is folded into pending before the exit decision below.
                if (neg_ok)      pend_eval = PEND_FALL;
                else if (pos_ok) pend_eval = PEND_NONE;
                if (cnt == '0) begin
                    pend_nx = PEND_NONE;
                    if (pend_eval == PEND_FALL) begin
                        sig_nx    = 1'b0;
                        tx_neg_nx = 1'b1;
                        cnt_nx    = RELOAD;
                        state_nx  = HOLD_LO;
                    end else begin
                        state_nx  = IDLE_HI;
                    end
                end else begin
                    cnt_nx  = cnt - 1'b1;
                    pend_nx = pend_eval;
                end
            end
            default: begin
                if (pos_ok)      pend_eval = PEND_RISE;
                else if (neg_ok) pend_eval = PEND_NONE;
                if (cnt == '0) begin
                    pend_nx = PEND_NONE;
                    if (pend_eval == PEND_RISE) begin
                        sig_nx    = 1'b1;
                        tx_pos_nx = 1'b1;
                        cnt_nx    = RELOAD;
                        state_nx  = HOLD_HI;
                    end else begin
                        state_nx  = IDLE_LO;
                    end
                end else begin
                    cnt_nx  = cnt - 1'b1;
                    pend_nx = pend_eval;
                end
            end
        endcase
    end

    // A conflicting pair only masks the requests; an ongoing dwell keeps counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE_LO;
            pend     <= PEND_NONE;
            cnt      <= '0;
            sig_q    <= 1'b0;
            tx_pos_q <= 1'b0;
            tx_neg_q <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            pend     <= pend_nx;
            cnt      <= cnt_nx;
            sig_q    <= sig_nx;
            tx_pos_q <= tx_pos_nx;
            tx_neg_q <= tx_neg_nx;
            busy_q   <= (state_nx == HOLD_HI) || (state_nx == HOLD_LO);
            drop_q   <= conflict;
        end
    end

    assign bus.sig_out  = sig_q;
    assign bus.tx_pos   = tx_pos_q;
    assign bus.tx_neg   = tx_neg_q;
    assign bus.busy     = busy_q;
    assign bus.req_drop = drop_q;
    assign bus.state    = state;

endmodule
